// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared 1-bit full adder, one bit per clock, LSB first.
// Optional subtract mode (sub port, two's-complement of op_b) enabled by defining SERIAL_ADD_SUB_EN.

module full_adder_with_enable (
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    always_comb begin
        sum  = 1'b0;
        cout = 1'b0;
        if (en) begin
            sum  = a ^ b ^ cin;
            cout = (a & b) | (a & cin) | (b & cin);
        end
    end
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             accept;
    logic             add_en;
    logic             add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so the inverted operand and forced carry are loaded at start.
    assign b_load = sub ? ~op_b : op_b;
    assign c_load = sub ? 1'b1 : cin_in;
`else
    assign b_load = op_b;
    assign c_load = cin_in;
`endif

    full_adder_with_enable u_fa (
        .en   (add_en),
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_en    = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                add_en = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The visible result is written only on the final bit so it stays stable throughout RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a     <= '0;
            sh_b     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout_out <= 1'b0;
        end else if (accept) begin
            sh_a  <= op_a;
            sh_b  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (add_en) begin
            carry  <= add_cout;
            res_sh <= {add_sum, res_sh[WIDTH-1:1]};
            sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                result   <= {add_sum, res_sh[WIDTH-1:1]};
                cout_out <= add_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus hand-written multi-cycle sequences.
// Subtract checks are built only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;
    localparam int NVEC  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_out;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] res;
        logic             cout;
    } vec_t;

    vec_t vecs [NVEC];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin_in   (cin_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_out (cout_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one operation from IDLE and returns the number of edges from acceptance to done.
    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c, output int lat);
        op_a   = a;
        op_b   = b;
        cin_in = c;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int gap;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        cin_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub    = 1'b0;
`endif
        tick();
        tick();
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_result", 32'(result), 32'd0);
        check_output("reset_cout", 32'(cout_out), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(WIDTH));
            check_output($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            check_output($sformatf("vec%0d_cout", i), 32'(cout_out), 32'(vecs[i].cout));
            check_output($sformatf("vec%0d_busy_in_done", i), 32'(busy), 32'd1);
            tick();
            check_output($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check_output($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        $display("[TB] start pulsed during RUN");
        op_a   = 8'h11;
        op_b   = 8'h22;
        cin_in = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 50) begin
            if (lat == 2) begin
                op_a   = 8'hF0;
                op_b   = 8'hF0;
                cin_in = 1'b1;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (lat == 4) check_output("run_result_held", 32'(result), 32'h4B);
        end
        start = 1'b0;
        check_output("ignore_latency", 32'(lat), 32'(WIDTH));
        check_output("ignore_result", 32'(result), 32'h33);
        check_output("ignore_cout", 32'(cout_out), 32'd0);
        tick();
        tick();
        check_output("ignore_not_queued", 32'(busy), 32'd0);

        $display("[TB] reset mid-operation");
        op_a   = 8'h55;
        op_b   = 8'h55;
        cin_in = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_output("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_done", 32'(done), 32'd0);
        check_output("midrst_result", 32'(result), 32'd0);
        check_output("midrst_cout", 32'(cout_out), 32'd0);
        rst_n = 1'b1;
        tick();
        apply_stimulus(8'h0F, 8'h01, 1'b0, lat);
        check_output("postrst_latency", 32'(lat), 32'(WIDTH));
        check_output("postrst_result", 32'(result), 32'h10);
        check_output("postrst_cout", 32'(cout_out), 32'd0);
        tick();

        $display("[TB] start held high back-to-back");
        op_a   = 8'h12;
        op_b   = 8'h34;
        cin_in = 1'b0;
        start  = 1'b1;
        tick();
        op_a = 8'h80;
        op_b = 8'h80;
        lat  = 0;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        check_output("b2b_first_latency", 32'(lat), 32'(WIDTH));
        check_output("b2b_first_result", 32'(result), 32'h46);
        check_output("b2b_first_cout", 32'(cout_out), 32'd0);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!done && gap < 50);
        start = 1'b0;
        check_output("b2b_gap", 32'(gap), 32'(WIDTH + 2));
        check_output("b2b_second_result", 32'(result), 32'h00);
        check_output("b2b_second_cout", 32'(cout_out), 32'd1);
        tick();
        tick();
        check_output("b2b_idle_after", 32'(busy), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
        $display("[TB] subtract mode");
        sub = 1'b1;
        apply_stimulus(8'h05, 8'h07, 1'b0, lat);
        check_output("sub_borrow_result", 32'(result), 32'hFE);
        check_output("sub_borrow_cout", 32'(cout_out), 32'd0);
        tick();
        apply_stimulus(8'h07, 8'h05, 1'b1, lat);
        check_output("sub_noborrow_result", 32'(result), 32'h02);
        check_output("sub_noborrow_cout", 32'(cout_out), 32'd1);
        tick();
        sub = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
